boot_seq_ctrl: RTL and testbench
================================

Name: boot_seq_ctrl

Overview:
Synthesizable SoC bring-up sequencer. It takes over what the simulation bench currently does by hand:
- holds the SoC in reset, then releases it;
- programs the boot-address register over a simple config-bus master;
- triggers and awaits an external memory loader (preload or SPI);
- raises fetch_enable;
- monitors the end-of-computation GPIO with a cycle watchdog.

It sits between the board-level start/mode straps and the pulpino_top control pins, and is usable both in the FPGA wrapper and in the bench.

Parameters:
RST_HOLD_CYC, 50, cycles soc_rst_no is held low after start (500 ns at 100 MHz)
SETTLE_CYC, 50, cycles between reset release and first config access
FETCH_DLY_CYC, 20, cycles between load completion and fetch_enable assertion
BOOT_REG_ADDR, 32'h1A10_7008, address of the boot-address register
BOOT_ADDR, 32'h0000_0000, value written to BOOT_REG_ADDR
EOC_BIT, 8, gpio_out_i bit index signalling end of computation (0..31)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  start request, level-sampled
mode_i  in  2  boot mode, sampled at start: 0 STANDALONE, 1 PRELOAD, 2 SPI, 3 reserved
timeout_i  in  32  RUN watchdog limit in cycles; 0 disables the watchdog
soc_rst_no  out  1  SoC reset, active low
cfg_req_o  out  1  config write request
cfg_addr_o  out  32  config address
cfg_wdata_o  out  32  config write data
cfg_gnt_i  in  1  request accepted
cfg_rvalid_i  in  1  write response valid
cfg_err_i  in  1  write error, qualified by cfg_rvalid_i
load_start_o  out  1  one-cycle pulse that starts the external loader
load_mode_o  out  2  latched mode_i, for the loader
load_done_i  in  1  loader finished
load_err_i  in  1  loader error, qualified by load_done_i
fetch_enable_o  out  1  core fetch enable
gpio_out_i  in  32  SoC GPIO outputs
done_o  out  1  sequence finished
status_o  out  2  0 BUSY/IDLE, 1 PASS, 2 ERROR, 3 TIMEOUT
run_cycles_o  out  32  cycles spent in RUN, saturating

Behaviour:
- Reset values (asynchronous on rst_n low, valid in any state, including mid-transaction):
  - soc_rst_no=0
  - cfg_req_o=0; cfg_addr_o=0; cfg_wdata_o=0
  - load_start_o=0; load_mode_o=0
  - fetch_enable_o=0
  - done_o=0; status_o=0; run_cycles_o=0
  - state IDLE
- IDLE: soc_rst_no=0. On start_i=1: latch mode_i into load_mode_o, then go to RST_HOLD.
- RST_HOLD: soc_rst_no=0 for exactly RST_HOLD_CYC cycles, then go to SETTLE with soc_rst_no=1 from the first SETTLE cycle onward.
- SETTLE: wait SETTLE_CYC cycles, then:
  - mode 0 → FETCH_DLY
  - mode 1 or 2 → CFG_REQ
  - mode 3 → DONE, status ERROR
- CFG_REQ:
  - cfg_req_o=1, cfg_addr_o=BOOT_REG_ADDR, cfg_wdata_o=BOOT_ADDR, all held stable until cfg_gnt_i=1 is sampled.
  - cfg_req_o drops in the cycle after the grant; go to CFG_WAIT.
- CFG_WAIT: wait for cfg_rvalid_i.
  - cfg_err_i=1 → DONE, ERROR.
  - Otherwise → LOAD_GO.
  - cfg_rvalid_i arriving in the same cycle as the grant is legal; consume it and skip CFG_WAIT.
- LOAD_GO: load_start_o=1 for one cycle → LOAD_WAIT.
- LOAD_WAIT: wait for load_done_i.
  - load_err_i=1 → DONE, ERROR.
  - Otherwise → FETCH_DLY.
- FETCH_DLY: wait FETCH_DLY_CYC cycles → RUN, with fetch_enable_o=1 from the first RUN cycle.
- RUN:
  - run_cycles_o increments every cycle and saturates at all-ones.
  - gpio_out_i[EOC_BIT]=1 → DONE, PASS.
  - Otherwise, if timeout_i≠0 and run_cycles_o+1 ≥ timeout_i → DONE, TIMEOUT.
  - EOC and timeout in the same cycle → PASS (EOC has priority).
- DONE:
  - done_o=1; fetch_enable_o=0 (cleared on entry); soc_rst_no unchanged; status_o held.
  - start_i=1 → clear done_o, status_o and run_cycles_o; relatch mode; go to RST_HOLD.
- start_i is ignored in every state except IDLE and DONE.
- cfg_gnt_i, cfg_rvalid_i and load_done_i are ignored outside their wait states.
- A zero-valued cycle parameter means the state lasts exactly 1 cycle.

Decomposition:
- Package boot_seq_pkg:
  - state enum: IDLE, RST_HOLD, SETTLE, CFG_REQ, CFG_WAIT, LOAD_GO, LOAD_WAIT, FETCH_DLY, RUN, DONE
  - status codes (BUSY, PASS, ERROR, TIMEOUT)
  - mode codes (STANDALONE, PRELOAD, SPI, RSVD)
- Sub-module boot_seq_timer: one loadable down-counter with load/en inputs and a zero flag, shared by RST_HOLD, SETTLE and FETCH_DLY.

Test Plan:
- mode=1, cfg_gnt_i after 3 cycles, rvalid one cycle later, load_done_i 10 cycles after the pulse, EOC at 100 RUN cycles:
  - soc_rst_no rises exactly 50 cycles after start
  - cfg_addr_o=1A107008 / cfg_wdata_o=0 held stable while waiting for the grant
  - fetch_enable_o rises 20 cycles after load_done_i
  - done_o=1, status=1, run_cycles_o=100
- mode=0 → no cfg_req_o and no load_start_o pulse; fetch_enable_o rises 70 cycles after reset release... more precisely SETTLE (50) + FETCH_DLY (20) cycles after soc_rst_no rises.
- mode=2, cfg_rvalid_i with cfg_err_i=1 → DONE, status=2, fetch_enable_o never asserted, load_start_o never pulsed.
- timeout_i=64, EOC never asserted → status=3 with run_cycles_o=64, fetch_enable_o=0. Repeat with EOC arriving on the same cycle as the timeout → status=1.
- rst_n pulsed low during LOAD_WAIT → all outputs return to reset values immediately; the next start_i reruns the full sequence.
- start_i asserted in DONE → status clears to 0 and soc_rst_no is driven low again for 50 cycles. Also: mode=3 → status=2 immediately after SETTLE.

Source files
------------

// File: rtl/boot_seq_pkg.sv
`default_nettype none
// ============================================================================
// boot_seq_pkg : shared types and helpers for the SoC bring-up sequencer
// Revision     : 1.0
// ============================================================================
package boot_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_HOLD  = 4'd1,
        ST_SETTLE    = 4'd2,
        ST_CFG_REQ   = 4'd3,
        ST_CFG_WAIT  = 4'd4,
        ST_LOAD_GO   = 4'd5,
        ST_LOAD_WAIT = 4'd6,
        ST_FETCH_DLY = 4'd7,
        ST_RUN       = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        STAT_BUSY    = 2'd0,
        STAT_PASS    = 2'd1,
        STAT_ERROR   = 2'd2,
        STAT_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        MODE_STANDALONE = 2'd0,
        MODE_PRELOAD    = 2'd1,
        MODE_SPI        = 2'd2,
        MODE_RSVD       = 2'd3
    } mode_e;

    // A timed state of N cycles loads N-1; zero still yields one cycle.
    function automatic int unsigned cyc_to_load(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage : boot_seq_pkg
`default_nettype wire

// File: rtl/boot_seq_timer.sv
`default_nettype none
// ============================================================================
// boot_seq_timer : loadable down-counter with zero flag for timed states
// Revision       : 1.0
// ============================================================================
module boot_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : boot_seq_timer
`default_nettype wire

// File: rtl/boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// boot_seq_ctrl : SoC bring-up sequencer (reset, boot-address write, loader
//                 handshake, fetch enable and end-of-computation watchdog)
// Revision      : 1.0
// ============================================================================
module boot_seq_ctrl
    import boot_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC  = 50,
    parameter int unsigned SETTLE_CYC    = 50,
    parameter int unsigned FETCH_DLY_CYC = 20,
    parameter logic [31:0] BOOT_REG_ADDR = 32'h1A10_7008,
    parameter logic [31:0] BOOT_ADDR     = 32'h0000_0000,
    parameter int unsigned EOC_BIT       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] timeout_i,
    output logic        soc_rst_no,
    output logic        cfg_req_o,
    output logic [31:0] cfg_addr_o,
    output logic [31:0] cfg_wdata_o,
    input  logic        cfg_gnt_i,
    input  logic        cfg_rvalid_i,
    input  logic        cfg_err_i,
    output logic        load_start_o,
    output logic [1:0]  load_mode_o,
    input  logic        load_done_i,
    input  logic        load_err_i,
    output logic        fetch_enable_o,
    input  logic [31:0] gpio_out_i,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] run_cycles_o
);

    localparam int unsigned TMR_W = timer_width(RST_HOLD_CYC, SETTLE_CYC, FETCH_DLY_CYC);
    localparam logic [TMR_W-1:0] c_rst_load    = TMR_W'(cyc_to_load(RST_HOLD_CYC));
    localparam logic [TMR_W-1:0] c_settle_load = TMR_W'(cyc_to_load(SETTLE_CYC));
    localparam logic [TMR_W-1:0] c_fetch_load  = TMR_W'(cyc_to_load(FETCH_DLY_CYC));

    state_e      state_q, state_d;
    logic        soc_rst_n_q, soc_rst_n_d;
    logic        cfg_req_q, cfg_req_d;
    logic [31:0] cfg_addr_q, cfg_addr_d;
    logic [31:0] cfg_wdata_q, cfg_wdata_d;
    logic        load_start_q, load_start_d;
    mode_e       load_mode_q, load_mode_d;
    logic        fetch_enable_q, fetch_enable_d;
    logic        done_q, done_d;
    status_e     status_q, status_d;
    logic [31:0] run_cycles_q, run_cycles_d;

    logic             tmr_load;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [32:0]      run_inc;
    logic             eoc;
    logic             unused_gpio;

    boot_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // One extra bit so the watchdog compare still works at saturation.
    assign run_inc     = {1'b0, run_cycles_q} + 33'd1;
    assign eoc         = gpio_out_i[EOC_BIT];
    assign unused_gpio = ^gpio_out_i;

    always_comb begin
        state_d        = state_q;
        soc_rst_n_d    = soc_rst_n_q;
        cfg_req_d      = cfg_req_q;
        cfg_addr_d     = cfg_addr_q;
        cfg_wdata_d    = cfg_wdata_q;
        load_start_d   = 1'b0;
        load_mode_d    = load_mode_q;
        fetch_enable_d = fetch_enable_q;
        done_d         = done_q;
        status_d       = status_q;
        run_cycles_d   = run_cycles_q;
        tmr_load       = 1'b0;
        tmr_en         = 1'b0;
        tmr_val        = '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d      = ST_RST_HOLD;
                    soc_rst_n_d  = 1'b0;
                    done_d       = 1'b0;
                    status_d     = STAT_BUSY;
                    run_cycles_d = '0;
                    load_mode_d  = mode_e'(mode_i);
                    tmr_load     = 1'b1;
                    tmr_val      = c_rst_load;
                end
            end
            ST_RST_HOLD: begin
                if (tmr_zero) begin
                    state_d     = ST_SETTLE;
                    soc_rst_n_d = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = c_settle_load;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    case (load_mode_q)
                        MODE_STANDALONE: begin
                            state_d  = ST_FETCH_DLY;
                            tmr_load = 1'b1;
                            tmr_val  = c_fetch_load;
                        end
                        MODE_PRELOAD, MODE_SPI: begin
                            state_d     = ST_CFG_REQ;
                            cfg_req_d   = 1'b1;
                            cfg_addr_d  = BOOT_REG_ADDR;
                            cfg_wdata_d = BOOT_ADDR;
                        end
                        default: begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            status_d = STAT_ERROR;
                        end
                    endcase
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_CFG_REQ: begin
                if (cfg_gnt_i) begin
                    cfg_req_d   = 1'b0;
                    cfg_addr_d  = '0;
                    cfg_wdata_d = '0;
                    // A response in the grant cycle is consumed right here.
                    if (cfg_rvalid_i && cfg_err_i) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        status_d = STAT_ERROR;
                    end else if (cfg_rvalid_i) begin
                        state_d      = ST_LOAD_GO;
                        load_start_d = 1'b1;
                    end else begin
                        state_d = ST_CFG_WAIT;
                    end
                end
            end
            ST_CFG_WAIT: begin
                if (cfg_rvalid_i && cfg_err_i) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    status_d = STAT_ERROR;
                end else if (cfg_rvalid_i) begin
                    state_d      = ST_LOAD_GO;
                    load_start_d = 1'b1;
                end
            end
            ST_LOAD_GO: begin
                state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (load_done_i && load_err_i) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    status_d = STAT_ERROR;
                end else if (load_done_i) begin
                    state_d  = ST_FETCH_DLY;
                    tmr_load = 1'b1;
                    tmr_val  = c_fetch_load;
                end
            end
            ST_FETCH_DLY: begin
                if (tmr_zero) begin
                    state_d        = ST_RUN;
                    fetch_enable_d = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RUN: begin
                run_cycles_d = run_inc[32] ? '1 : run_inc[31:0];
                if (eoc) begin
                    state_d        = ST_DONE;
                    done_d         = 1'b1;
                    status_d       = STAT_PASS;
                    fetch_enable_d = 1'b0;
                end else if ((timeout_i != '0) && (run_inc >= {1'b0, timeout_i})) begin
                    state_d        = ST_DONE;
                    done_d         = 1'b1;
                    status_d       = STAT_TIMEOUT;
                    fetch_enable_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            soc_rst_n_q    <= 1'b0;
            cfg_req_q      <= 1'b0;
            cfg_addr_q     <= '0;
            cfg_wdata_q    <= '0;
            load_start_q   <= 1'b0;
            load_mode_q    <= MODE_STANDALONE;
            fetch_enable_q <= 1'b0;
            done_q         <= 1'b0;
            status_q       <= STAT_BUSY;
            run_cycles_q   <= '0;
        end else begin
            state_q        <= state_d;
            soc_rst_n_q    <= soc_rst_n_d;
            cfg_req_q      <= cfg_req_d;
            cfg_addr_q     <= cfg_addr_d;
            cfg_wdata_q    <= cfg_wdata_d;
            load_start_q   <= load_start_d;
            load_mode_q    <= load_mode_d;
            fetch_enable_q <= fetch_enable_d;
            done_q         <= done_d;
            status_q       <= status_d;
            run_cycles_q   <= run_cycles_d;
        end
    end

    assign soc_rst_no     = soc_rst_n_q;
    assign cfg_req_o      = cfg_req_q;
    assign cfg_addr_o     = cfg_addr_q;
    assign cfg_wdata_o    = cfg_wdata_q;
    assign load_start_o   = load_start_q;
    assign load_mode_o    = load_mode_q;
    assign fetch_enable_o = fetch_enable_q;
    assign done_o         = done_q;
    assign status_o       = status_q;
    assign run_cycles_o   = run_cycles_q;

endmodule : boot_seq_ctrl
`default_nettype wire

// File: tb/tb_boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_boot_seq_ctrl : directed table plus randomized scenarios for boot_seq_ctrl
// Revision         : 1.0
// ============================================================================
module tb_boot_seq_ctrl;

    localparam int          RST_HOLD  = 50;
    localparam int          SETTLE    = 50;
    localparam int          FETCH_DLY = 20;
    localparam logic [31:0] REG_ADDR  = 32'h1A10_7008;
    localparam logic [31:0] BOOT_VAL  = 32'h0000_0000;
    localparam int          EOC_BIT   = 8;
    localparam int          BUDGET    = 2000;
    localparam logic [31:0] EOC_MASK  = 32'h0000_0100;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        start_i      = 1'b0;
    logic [1:0]  mode_i       = 2'd0;
    logic [31:0] timeout_i    = 32'd0;
    logic        cfg_gnt_i    = 1'b0;
    logic        cfg_rvalid_i = 1'b0;
    logic        cfg_err_i    = 1'b0;
    logic        load_done_i  = 1'b0;
    logic        load_err_i   = 1'b0;
    logic [31:0] gpio_out_i   = 32'd0;
    logic        soc_rst_no;
    logic        cfg_req_o;
    logic [31:0] cfg_addr_o;
    logic [31:0] cfg_wdata_o;
    logic        load_start_o;
    logic [1:0]  load_mode_o;
    logic        fetch_enable_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic [31:0] run_cycles_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    boot_seq_ctrl #(
        .RST_HOLD_CYC  (RST_HOLD),
        .SETTLE_CYC    (SETTLE),
        .FETCH_DLY_CYC (FETCH_DLY),
        .BOOT_REG_ADDR (REG_ADDR),
        .BOOT_ADDR     (BOOT_VAL),
        .EOC_BIT       (EOC_BIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .timeout_i      (timeout_i),
        .soc_rst_no     (soc_rst_no),
        .cfg_req_o      (cfg_req_o),
        .cfg_addr_o     (cfg_addr_o),
        .cfg_wdata_o    (cfg_wdata_o),
        .cfg_gnt_i      (cfg_gnt_i),
        .cfg_rvalid_i   (cfg_rvalid_i),
        .cfg_err_i      (cfg_err_i),
        .load_start_o   (load_start_o),
        .load_mode_o    (load_mode_o),
        .load_done_i    (load_done_i),
        .load_err_i     (load_err_i),
        .fetch_enable_o (fetch_enable_o),
        .gpio_out_i     (gpio_out_i),
        .done_o         (done_o),
        .status_o       (status_o),
        .run_cycles_o   (run_cycles_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mode;
        int gnt_dly;
        int rv_dly;
        int cfg_err;
        int ld_dly;
        int ld_err;
        int eoc_at;
        int timeout;
        int rst_in_load;
        int exp_status;
        int exp_run;
    } scen_t;

    function automatic scen_t mk(int mode, int gnt, int rv, int cerr, int ld, int lerr,
                                 int eoc, int to, int rl, int es, int er);
        scen_t s;
        s.mode = mode; s.gnt_dly = gnt; s.rv_dly = rv; s.cfg_err = cerr;
        s.ld_dly = ld; s.ld_err = lerr; s.eoc_at = eoc; s.timeout = to;
        s.rst_in_load = rl; s.exp_status = es; s.exp_run = er;
        return s;
    endfunction

    // Outcome straight from the sequencing rules: which failure ends the run first.
    function automatic scen_t model(scen_t s);
        scen_t r = s;
        if (s.mode == 3 || (s.mode != 0 && (s.cfg_err != 0 || s.ld_err != 0))) begin
            r.exp_status = 2; r.exp_run = 0;
        end else if (s.eoc_at != 0 && (s.timeout == 0 || s.eoc_at <= s.timeout)) begin
            r.exp_status = 1; r.exp_run = s.eoc_at;
        end else begin
            r.exp_status = 3; r.exp_run = s.timeout;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        start_i = 1'b0; cfg_gnt_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_err_i = 1'b0;
        load_done_i = 1'b0; load_err_i = 1'b0; gpio_out_i = 32'd0;
    endtask

    task automatic run_scen(input scen_t s);
        int start_c, rst_rise, req_first, req_cnt, gnt_c, ld_pulse, ld_pulses;
        int ld_drv, fetch_rise, fetch_cnt, done_c, addr_bad;
        bit eoc_on, cfg_path, junk;
        rst_rise = -1; req_first = -1; req_cnt = 0; gnt_c = -1; ld_pulse = -1;
        ld_pulses = 0; ld_drv = -1; fetch_rise = -1; fetch_cnt = 0; done_c = -1;
        addr_bad = 0; eoc_on = 1'b0;

        @(negedge clk);
        start_i   = 1'b1;
        mode_i    = 2'(s.mode);
        timeout_i = 32'(s.timeout);
        start_c   = cyc;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("restart_clear", 128'({soc_rst_no, done_o, status_o, run_cycles_o}), 128'(0));
                check("mode_latch", 128'(load_mode_o), 128'(s.mode));
            end
            if (rst_rise < 0 && soc_rst_no) rst_rise = cyc;
            if (cfg_req_o) begin
                if (req_first < 0) req_first = cyc;
                req_cnt++;
                if (cfg_addr_o !== REG_ADDR || cfg_wdata_o !== BOOT_VAL) addr_bad++;
            end
            if (load_start_o) begin ld_pulses++; ld_pulse = cyc; end
            if (fetch_enable_o) begin
                if (fetch_rise < 0) fetch_rise = cyc;
                fetch_cnt++;
            end
            if (done_o) begin done_c = cyc; break; end

            if (s.rst_in_load != 0 && ld_pulse >= 0 && cyc == ld_pulse + 3) begin
                quiet_inputs();
                rst_n = 1'b0;
                #1;
                check("async_reset", 128'({soc_rst_no, cfg_req_o, cfg_addr_o, cfg_wdata_o,
                      load_start_o, load_mode_o, fetch_enable_o, done_o, status_o,
                      run_cycles_o}), 128'(0));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end

            // Inputs that the sequencer must ignore in its current phase get noise.
            junk         = (req_first < 0 && ld_pulse < 0) || fetch_enable_o;
            start_i      = 1'($urandom % 2);
            mode_i       = 2'($urandom % 4);
            cfg_gnt_i    = junk ? 1'($urandom % 2) : 1'b0;
            cfg_rvalid_i = junk ? 1'($urandom % 2) : 1'b0;
            cfg_err_i    = junk ? 1'($urandom % 2) : 1'b0;
            load_done_i  = junk ? 1'($urandom % 2) : 1'b0;
            load_err_i   = junk ? 1'($urandom % 2) : 1'b0;

            if (cfg_req_o && req_cnt == s.gnt_dly + 1) begin
                cfg_gnt_i = 1'b1;
                gnt_c     = cyc;
                if (s.rv_dly == 0) begin cfg_rvalid_i = 1'b1; cfg_err_i = 1'(s.cfg_err); end
            end
            if (gnt_c >= 0 && s.rv_dly > 0 && cyc == gnt_c + s.rv_dly) begin
                cfg_rvalid_i = 1'b1; cfg_err_i = 1'(s.cfg_err);
            end
            if (ld_pulse >= 0 && cyc == ld_pulse + s.ld_dly) begin
                load_done_i = 1'b1; load_err_i = 1'(s.ld_err); ld_drv = cyc;
            end
            if (fetch_enable_o && s.eoc_at != 0 && (cyc - fetch_rise + 1) >= s.eoc_at) eoc_on = 1'b1;
            gpio_out_i = ($urandom & ~EOC_MASK) | (eoc_on ? EOC_MASK : 32'd0);
        end
        quiet_inputs();

        if (done_c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_wait: done_o still 0 after %0d cycles, expected 1", BUDGET);
            return;
        end
        check("status", 128'(status_o), 128'(s.exp_status));
        check("run_cycles", 128'(run_cycles_o), 128'(s.exp_run));
        check("fetch_off_in_done", 128'(fetch_enable_o), 128'(0));
        check("soc_rst_in_done", 128'(soc_rst_no), 128'(1));
        check("rst_hold_len", 128'(rst_rise - (start_c + 1)), 128'(RST_HOLD));
        cfg_path = (s.mode == 1 || s.mode == 2);
        check("cfg_req_seen", 128'(req_first >= 0), 128'(cfg_path));
        if (cfg_path) begin
            check("settle_len", 128'(req_first - rst_rise), 128'(SETTLE));
            check("req_hold", 128'(req_cnt), 128'(s.gnt_dly + 1));
            check("addr_stable", 128'(addr_bad), 128'(0));
        end
        check("load_pulses", 128'(ld_pulses), 128'((cfg_path && s.cfg_err == 0) ? 1 : 0));
        check("fetch_cycles", 128'(fetch_cnt),
              128'((s.exp_status == 1 || s.exp_status == 3) ? s.exp_run : 0));
        if (fetch_rise >= 0 && s.mode == 0)
            check("fetch_after_rst", 128'(fetch_rise - rst_rise), 128'(SETTLE + FETCH_DLY));
        if (fetch_rise >= 0 && ld_drv >= 0)
            check("fetch_after_load", 128'(fetch_rise - (ld_drv + 1)), 128'(FETCH_DLY));
        if (s.mode == 3)
            check("rsvd_done_time", 128'(done_c - rst_rise), 128'(SETTLE));
    endtask

    scen_t tbl [11];
    scen_t rs;

    initial begin
        #2;
        check("por_outputs", 128'({soc_rst_no, cfg_req_o, cfg_addr_o, cfg_wdata_o, load_start_o,
              load_mode_o, fetch_enable_o, done_o, status_o, run_cycles_o}), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hold", 128'({soc_rst_no, done_o, status_o}), 128'(0));

        //            mode gnt rv cerr ld lerr eoc  to  rl  st  run
        tbl[0]  = mk(1,   3,  1, 0,  10, 0,  100, 0,  0,  1,  100);
        tbl[1]  = mk(0,   0,  0, 0,  1,  0,  30,  0,  0,  1,  30);
        tbl[2]  = mk(2,   0,  0, 1,  1,  0,  10,  0,  0,  2,  0);
        tbl[3]  = mk(1,   1,  2, 0,  5,  0,  0,   64, 0,  3,  64);
        tbl[4]  = mk(1,   0,  1, 0,  3,  0,  64,  64, 0,  1,  64);
        tbl[5]  = mk(3,   0,  0, 0,  1,  0,  10,  0,  0,  2,  0);
        tbl[6]  = mk(2,   2,  3, 0,  4,  1,  10,  0,  0,  2,  0);
        tbl[7]  = mk(1,   1,  1, 0,  10, 0,  10,  0,  1,  0,  0);
        tbl[8]  = mk(0,   0,  0, 0,  1,  0,  1,   1,  0,  1,  1);
        tbl[9]  = mk(0,   0,  0, 0,  1,  0,  0,   1,  0,  3,  1);
        tbl[10] = mk(2,   0,  0, 0,  2,  0,  5,   6,  0,  1,  5);
        for (int i = 0; i < 11; i++) run_scen(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rs = mk(int'($urandom % 4), int'($urandom % 6), int'($urandom % 5),
                    ($urandom % 6 == 0) ? 1 : 0, 1 + int'($urandom % 12),
                    ($urandom % 6 == 0) ? 1 : 0, int'($urandom % 121), 0, 0, 0, 0);
            if (rs.eoc_at == 0) rs.timeout = 1 + int'($urandom % 120);
            else if ($urandom % 3 != 0) rs.timeout = 1 + int'($urandom % 120);
            run_scen(model(rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_boot_seq_ctrl
`default_nettype wire
